phys_reg_release_queue: RTL and testbench



---
 rtl/phys_reg_release_queue.sv | 178 +++++++++++++++++
 tb/tb_phys_reg_release_queue.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/phys_reg_release_queue.sv
// phys_reg_release_queue
//
// Producer side of the physical-register free list. Every renamed
// instruction is recorded in program order as {uses_rd, prev_phys, new_phys}
// in a circular buffer (head = oldest entry, tail = next free slot).
//   * In-order retire pops the head and returns prev_phys to the free list.
//   * Flush walks the unretired entries youngest-first, one per cycle, and
//     returns each speculatively allocated new_phys so that no register leaks.
//
// Ports
//   clk                     clock, all state updates on the rising edge
//   rst                     asynchronous, active-low reset
//   rename_valid            allocate an entry at the tail this cycle
//   rename_uses_rd          instruction popped a free-list register
//   rename_prev_phys        prior physical mapping of rd
//   rename_new_phys         register just popped from the free list
//   rename_ready            entry available and not draining (combinational)
//   retire_valid            head entry retires
//   flush                   discard all unretired entries
//   release_push            push one register index to the free list
//   release_potential_push  free-list storage write-enable (same as push)
//   release_data            register index being returned
//   release_full            free list full (checked by assertion only)
//   drain_busy              flush walk in progress
//   occupancy               entries currently held
module phys_reg_release_queue #(
  parameter int NUM_ENTRIES = 8,
  parameter int PHYS_ADDR_W = 6
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rename_valid,
  input  logic                          rename_uses_rd,
  input  logic [PHYS_ADDR_W-1:0]        rename_prev_phys,
  input  logic [PHYS_ADDR_W-1:0]        rename_new_phys,
  output logic                          rename_ready,
  input  logic                          retire_valid,
  input  logic                          flush,
  output logic                          release_push,
  output logic                          release_potential_push,
  output logic [PHYS_ADDR_W-1:0]        release_data,
  input  logic                          release_full,
  output logic                          drain_busy,
  output logic [$clog2(NUM_ENTRIES):0]  occupancy
);

  localparam int PTR_W = $clog2(NUM_ENTRIES);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NUM_ENTRIES);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] DRAIN = 1'b1;

  // Entry storage; contents are only meaningful between head and tail, so
  // it carries no reset.
  logic                   mem_uses [NUM_ENTRIES];
  logic [PHYS_ADDR_W-1:0] mem_prev [NUM_ENTRIES];
  logic [PHYS_ADDR_W-1:0] mem_new  [NUM_ENTRIES];

  logic [0:0]       state_q, state_d;
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] occ_q, occ_d;

  // Low for the first rising edge after reset is released, so that edge
  // still behaves as a reset edge and no state moves.
  logic             rst_done;

  logic             retire_fire;
  logic             rename_fire;
  logic [PTR_W-1:0] walk_ptr;
  logic [CNT_W-1:0] occ_after_retire;

  logic                   rel_vld_p0;
  logic [PHYS_ADDR_W-1:0] rel_data_p0;
  logic                   rel_vld_p1;
  logic [PHYS_ADDR_W-1:0] rel_data_p1;

  assign rename_ready = (state_q == IDLE) && (occ_q != FULL_CNT);

  assign retire_fire = rst_done && (state_q == IDLE) && retire_valid &&
                       (occ_q != '0);
  // A rename that arrives with a flush is dropped; the renamer rolls its
  // free-list pop back on its own side.
  assign rename_fire = rst_done && (state_q == IDLE) && rename_valid &&
                       rename_ready && !flush;

  // The youngest live entry is always just below the tail; the walk
  // shrinks the tail itself, so no separate walk register is needed.
  assign walk_ptr = tail_q - PTR_W'(1);

  assign occ_after_retire = occ_q - CNT_W'(retire_fire);

  // ---- stage p0: decide the next state and the release to issue ----
  always_comb begin
    state_d     = state_q;
    head_d      = head_q;
    tail_d      = tail_q;
    occ_d       = occ_q;
    rel_vld_p0  = 1'b0;
    rel_data_p0 = '0;
    if (state_q == IDLE) begin
      if (retire_fire) begin
        head_d = head_q + PTR_W'(1);
        if (mem_uses[head_q]) begin
          rel_vld_p0  = 1'b1;
          rel_data_p0 = mem_prev[head_q];
        end
      end
      if (rename_fire) begin
        tail_d = tail_q + PTR_W'(1);
      end
      occ_d = occ_q + CNT_W'(rename_fire) - CNT_W'(retire_fire);
      // The retire in the flush cycle has already been taken above; only
      // what is left behind it needs walking.
      if (rst_done && flush && (occ_after_retire != '0)) begin
        state_d = DRAIN;
      end
    end else begin
      if (mem_uses[walk_ptr]) begin
        rel_vld_p0  = 1'b1;
        rel_data_p0 = mem_new[walk_ptr];
      end
      tail_d = walk_ptr;
      occ_d  = occ_q - CNT_W'(1);
      if (occ_q == CNT_W'(1)) begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rename_fire) begin
      mem_uses[tail_q] <= rename_uses_rd;
      mem_prev[tail_q] <= rename_prev_phys;
      mem_new[tail_q]  <= rename_new_phys;
    end
  end

  // ---- stage p1: registered control state and release outputs ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rst_done    <= 1'b0;
      state_q     <= IDLE;
      head_q      <= '0;
      tail_q      <= '0;
      occ_q       <= '0;
      rel_vld_p1  <= 1'b0;
      rel_data_p1 <= '0;
    end else begin
      rst_done <= 1'b1;
      if (rst_done) begin
        state_q     <= state_d;
        head_q      <= head_d;
        tail_q      <= tail_d;
        occ_q       <= occ_d;
        rel_vld_p1  <= rel_vld_p0;
        rel_data_p1 <= rel_data_p0;
      end
    end
  end

  assign release_push           = rel_vld_p1;
  assign release_potential_push = rel_vld_p1;
  assign release_data           = rel_data_p1;
  assign drain_busy             = (state_q == DRAIN);
  assign occupancy              = occ_q;

  a_rename_when_ready: assert property (@(posedge clk) disable iff (!rst)
    !(rename_valid && !rename_ready));
  a_retire_nonempty: assert property (@(posedge clk) disable iff (!rst)
    !((state_q == IDLE) && retire_valid && (occ_q == '0)));
  a_no_retire_in_drain: assert property (@(posedge clk) disable iff (!rst)
    !((state_q == DRAIN) && retire_valid));
  a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst)
    !(release_push && release_full));

endmodule

// File: tb/tb_phys_reg_release_queue.sv
// Randomized and directed bench for phys_reg_release_queue with an in-bench
// queue-based reference model of the release queue.
module tb_phys_reg_release_queue;

  localparam int N  = 8;
  localparam int PW = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          rename_valid = 1'b0;
  logic          rename_uses_rd = 1'b0;
  logic [PW-1:0] rename_prev_phys = '0;
  logic [PW-1:0] rename_new_phys = '0;
  logic          rename_ready;
  logic          retire_valid = 1'b0;
  logic          flush = 1'b0;
  logic          release_push;
  logic          release_potential_push;
  logic [PW-1:0] release_data;
  logic          release_full = 1'b0;
  logic          drain_busy;
  logic [3:0]    occupancy;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en = 1'b0;

  phys_reg_release_queue #(.NUM_ENTRIES(N), .PHYS_ADDR_W(PW)) dut (
    .clk(clk), .rst(rst),
    .rename_valid(rename_valid), .rename_uses_rd(rename_uses_rd),
    .rename_prev_phys(rename_prev_phys), .rename_new_phys(rename_new_phys),
    .rename_ready(rename_ready), .retire_valid(retire_valid), .flush(flush),
    .release_push(release_push), .release_potential_push(release_potential_push),
    .release_data(release_data), .release_full(release_full),
    .drain_busy(drain_busy), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the in-flight instructions as a program-ordered queue.
  typedef struct packed {
    logic          u;
    logic [PW-1:0] p;
    logic [PW-1:0] n;
  } ent_t;

  ent_t          mq[$];
  ent_t          me;
  bit            m_drain = 1'b0;
  bit            m_ready;
  bit            exp_push = 1'b0;
  logic [PW-1:0] exp_data = '0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq.delete();
      m_drain  = 1'b0;
      exp_push = 1'b0;
      exp_data = '0;
    end else begin
      exp_push = 1'b0;
      exp_data = '0;
      if (m_drain) begin
        me = mq.pop_back();
        if (me.u) begin exp_push = 1'b1; exp_data = me.n; end
        if (mq.size() == 0) m_drain = 1'b0;
      end else begin
        m_ready = (mq.size() < N);
        if (retire_valid && mq.size() > 0) begin
          me = mq.pop_front();
          if (me.u) begin exp_push = 1'b1; exp_data = me.p; end
        end
        if (flush) begin
          if (mq.size() > 0) m_drain = 1'b1;
        end else if (rename_valid && m_ready) begin
          mq.push_back('{u: rename_uses_rd, p: rename_prev_phys, n: rename_new_phys});
        end
      end
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("ready", rename_ready, (!m_drain && mq.size() < N));
      chk("drain_busy", drain_busy, m_drain);
      chk("occupancy", occupancy, mq.size());
      chk("push", release_push, exp_push);
      chk("potential_push", release_potential_push, exp_push);
      if (exp_push) chk("data", release_data, exp_data);
    end
  end

  task automatic drive(input bit ren, input bit uses, input logic [PW-1:0] prev,
                       input logic [PW-1:0] nw, input bit ret, input bit fl);
    rename_valid     = ren;
    rename_uses_rd   = uses;
    rename_prev_phys = prev;
    rename_new_phys  = nw;
    retire_valid     = ret;
    flush            = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(0, 0, '0, '0, 0, 0);
  endtask

  initial begin
    bit ren, ret, fl;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    cmp_en = 1'b1;
    chk("reset_push", release_push, 0);
    chk("reset_occ", occupancy, 0);
    chk("reset_busy", drain_busy, 0);
    #2 rst = 1'b1;
    idle(); idle();

    // Rename three, retire three back to back.
    drive(1, 1, 6'd5, 6'd40, 0, 0);
    drive(1, 1, 6'd6, 6'd41, 0, 0);
    drive(1, 1, 6'd7, 6'd42, 0, 0);
    chk("t1_occ3", occupancy, 3);
    drive(0, 0, '0, '0, 1, 0);
    chk("t1_push5", release_push, 1); chk("t1_data5", release_data, 5);
    drive(0, 0, '0, '0, 1, 0);
    chk("t1_push6", release_push, 1); chk("t1_data6", release_data, 6);
    drive(0, 0, '0, '0, 1, 0);
    chk("t1_push7", release_push, 1); chk("t1_data7", release_data, 7);
    idle();
    chk("t1_nopush", release_push, 0); chk("t1_occ0", occupancy, 0);

    // Fill, then simultaneous rename/retire, then wrap the pointers.
    for (int i = 0; i < N; i++) drive(1, 1, PW'(i), PW'(32 + i), 0, 0);
    chk("t2_full_ready", rename_ready, 0); chk("t2_full_occ", occupancy, 8);
    for (int i = 0; i < 4; i++) drive(0, 0, '0, '0, 1, 0);
    chk("t2_occ4", occupancy, 4);
    drive(1, 1, 6'd50, 6'd51, 1, 0);
    chk("t2_pair_occ", occupancy, 4);
    chk("t2_pair_push", release_push, 1); chk("t2_pair_data", release_data, 4);
    for (int i = 0; i < 20; i++) drive(1, 1, PW'(20 + i), PW'(i), 1, 0);
    for (int i = 0; i < 4; i++) drive(0, 0, '0, '0, 1, 0);
    chk("t2_data_last", release_data, 39);
    idle();
    chk("t2_occ0", occupancy, 0);

    // Flush walk: pushes 13, (none for 12), 11, 10.
    drive(1, 1, 6'd1, 6'd10, 0, 0);
    drive(1, 1, 6'd2, 6'd11, 0, 0);
    drive(1, 0, 6'd3, 6'd12, 0, 0);
    drive(1, 1, 6'd4, 6'd13, 0, 0);
    drive(0, 0, '0, '0, 0, 1);
    chk("t3_busy0", drain_busy, 1); chk("t3_push0", release_push, 0);
    idle();
    chk("t3_busy1", drain_busy, 1); chk("t3_data13", release_data, 13);
    idle();
    chk("t3_busy2", drain_busy, 1); chk("t3_nopush12", release_push, 0);
    idle();
    chk("t3_busy3", drain_busy, 1); chk("t3_data11", release_data, 11);
    idle();
    chk("t3_busy4", drain_busy, 0); chk("t3_data10", release_data, 10);
    chk("t3_push10", release_push, 1);
    chk("t3_occ", occupancy, 0); chk("t3_ready", rename_ready, 1);
    idle();

    // Flush together with a retire of the head and a rename.
    drive(1, 1, 6'd3, 6'd20, 0, 0);
    drive(1, 1, 6'd8, 6'd21, 0, 0);
    drive(1, 1, 6'd9, 6'd22, 0, 0);
    drive(1, 1, 6'd60, 6'd63, 1, 1);
    chk("t4_push3", release_push, 1); chk("t4_data3", release_data, 3);
    chk("t4_occ2", occupancy, 2); chk("t4_busy", drain_busy, 1);
    idle();
    chk("t4_data22", release_data, 22);
    idle();
    chk("t4_data21", release_data, 21); chk("t4_done", drain_busy, 0);
    idle();
    chk("t4_occ0", occupancy, 0); chk("t4_quiet", release_push, 0);

    // Reset in the middle of a drain with two entries left.
    for (int i = 0; i < 4; i++) drive(1, 1, PW'(i), PW'(30 + i), 0, 0);
    drive(0, 0, '0, '0, 0, 1);
    idle();
    idle();
    chk("t5_data32", release_data, 32); chk("t5_occ2", occupancy, 2);
    #3 rst = 1'b0;
    #1;
    chk("t5_rst_push", release_push, 0); chk("t5_rst_data", release_data, 0);
    chk("t5_rst_busy", drain_busy, 0); chk("t5_rst_occ", occupancy, 0);
    @(posedge clk);
    #3 rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idle();
      chk("t5_after_push", release_push, 0); chk("t5_after_occ", occupancy, 0);
    end

    // Flush on an empty queue.
    drive(0, 0, '0, '0, 0, 1);
    chk("t6_busy", drain_busy, 0); chk("t6_push", release_push, 0);
    chk("t6_ready", rename_ready, 1);
    idle();

    // Randomized traffic.
    for (int c = 0; c < 2000; c++) begin
      if (m_drain) begin
        drive(0, 0, '0, '0, 0, 1'($urandom_range(0, 1)));
      end else begin
        ren = (mq.size() < N) && ($urandom_range(0, 9) < 6);
        ret = (mq.size() > 0) && ($urandom_range(0, 9) < 4);
        fl  = ($urandom_range(0, 15) == 0);
        drive(ren, 1'($urandom_range(0, 3) != 0), PW'($urandom), PW'($urandom), ret, fl);
      end
    end
    while (m_drain) idle();
    idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
